rule90_seed_loader: RTL and testbench
=====================================

# rule90_seed_loader

Upstream feeder for the 512-cell Rule 90 cellular-automaton core. Accepts a seed pattern as a stream of narrow words over a valid/ready handshake, assembles it into a full-width seed vector, and issues a single-cycle `load` pulse with the assembled vector on `data`. Handles short and overlong frames deterministically and reports them with sticky error flags.

## Interface
- `CA_W`, 512, automaton width in cells; must be an integer multiple of `WORD_W`.
- `WORD_W`, 32, stream word width; `WORDS = CA_W/WORD_W` must be ≥ 2.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  `WORD_W`  stream word; the first word of a frame fills cells `[WORD_W-1:0]`, ascending after that.
- `s_last`  in  1  marks the final word of a frame.
- `load`  out  1  one-cycle pulse; the core captures `data` on this cycle.
- `data`  out  `CA_W`  assembled seed; valid while `load`=1.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `err_short`  out  1  sticky; a frame ended with fewer than `WORDS` words.
- `err_long`  out  1  sticky; a frame had more than `WORDS` words.
- `err_clr`  in  1  synchronous clear of both error flags.

## Operation
- States: IDLE, FILL, DRAIN, COMMIT.
- Handshake: a word transfers on a cycle with `s_valid & s_ready`. `s_ready`=1 in IDLE, FILL and DRAIN, and 0 in COMMIT. `s_data` and `s_last` are sampled only on a transfer.
- IDLE, on a transfer: the assembly register clears to 0. The word is written to slot 0 and `idx` becomes 1.
  - If `s_last` is set, go to COMMIT and set `err_short`.
  - Otherwise go to FILL.
- FILL, on a transfer: the word is written to slot `idx` and `idx` increments.
  - If this is slot `WORDS-1` and `s_last` is set, go to COMMIT.
  - If this is slot `WORDS-1` and `s_last` is clear, go to DRAIN and set `err_long`.
  - If this is an earlier slot and `s_last` is set, go to COMMIT and set `err_short`. Unfilled slots stay zero.
- DRAIN: words are accepted and discarded. On a transfer with `s_last`, go to COMMIT.
- COMMIT: `load`=1 for exactly this one cycle. The next state is IDLE.
- `data` is the assembly register. It is stable from COMMIT until the next frame's first transfer.
- `idx` is `$clog2(WORDS)` bits wide. It resets to 0 on entry to IDLE and never wraps within a frame.
- Error flags: `err_clr` has priority over a same-cycle set. A set occurring on the same cycle as `err_clr` is lost.

## Timing
- Reset values: state IDLE, `load`=0, `data`=0, `busy`=0, `err_short`=0, `err_long`=0, `idx`=0. `s_ready`=1 once `rst_n` deasserts.
- Latency: `load` asserts on the cycle after the handshake of the terminating word.
- Throughput: one word per cycle. Each frame costs `WORDS`+1 cycles minimum, because of the COMMIT bubble.
- Back-to-back frames: the first word of the next frame may transfer on the cycle after COMMIT.
- Reset mid-frame: the partial frame is discarded. No `load` is issued and the flags are cleared.
- `s_valid` gaps in FILL or DRAIN are legal. State and `idx` hold during a gap.
- All outputs are registered except `s_ready`, which is decoded from the state register.

## Configuration
- `RULE90_SEED_LOADER_CNT_EN`
  - Defined: adds output port `load_cnt`, 16 bits, which increments on every COMMIT. It wraps from 0xFFFF to 0, resets to 0, and is unaffected by `err_clr`.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `rule90_pkg`:
  - the state enum (IDLE, FILL, DRAIN, COMMIT);
  - constants `RULE90_CA_W`=512 and `RULE90_WORD_W`=32.
- Single module. No sub-module is needed; the word-slot write is an indexed part-select into the assembly register.

## Test plan
- Reset, then 16 words 0x0000_0001…0x0000_0010 with `s_last` on word 16 -> one `load` pulse the cycle after word 16. `data[31:0]`=1, `data[511:480]`=0x10, both flags 0.
- Word 0xFFFF_FFFF with `s_last` on word 3 -> `load` asserts. `data[95:0]`=all ones, `data[511:96]`=0, `err_short`=1.
- 18 words with `s_last` on word 18 -> `err_long`=1 and `s_ready` stays 1 through DRAIN. A single `load` asserts after word 18, and `data` holds only words 1–16.
- Two frames back-to-back with `s_valid` held high -> `s_ready`=0 for exactly one cycle between them, with two `load` pulses 17 cycles apart. With `RULE90_SEED_LOADER_CNT_EN` defined, `load_cnt` reads 2.
- `rst_n` low after word 7 of a frame, then a full frame -> no `load` for the aborted frame, and `data` reflects only the new frame.
- `err_clr` asserted on the same cycle as a short-frame terminating word -> `err_short` remains 0.

Source files
------------

// File: rtl/rule90_pkg.sv
// Shared definitions for the Rule 90 automaton and its seed loader:
// default widths and the loader state encoding.
package rule90_pkg;

  localparam int RULE90_CA_W   = 512;
  localparam int RULE90_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/rule90_seed_loader_if.sv
// Seed word stream (valid/ready with end-of-frame marker) feeding the loader.
interface rule90_seed_loader_if
  import rule90_pkg::*;
#(
  parameter int WORD_W = RULE90_WORD_W
);

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/rule90_seed_loader.sv
// Assembles a streamed seed into a CA_W-bit vector and pulses load once per frame.
// Optional RULE90_SEED_LOADER_CNT_EN adds a 16-bit wrapping count of committed frames.
module rule90_seed_loader
  import rule90_pkg::*;
#(
  parameter int CA_W   = RULE90_CA_W,
  parameter int WORD_W = RULE90_WORD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rule90_seed_loader_if.slave  s,
  output logic                 load,
  output logic [CA_W-1:0]      data,
  output logic                 busy,
  output logic                 err_short,
  output logic                 err_long,
  input  logic                 err_clr
`ifdef RULE90_SEED_LOADER_CNT_EN
  ,
  output logic [15:0]          load_cnt
`endif
);

  localparam int WORDS = CA_W / WORD_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state;
  state_e           state_next;
  logic [IDX_W-1:0] idx;
  logic             xfer;
  logic             set_short;
  logic             set_long;

  // Ready is the only combinational output: it drops just for the COMMIT bubble.
  assign s.s_ready = (state != COMMIT);
  assign xfer      = s.s_valid & s.s_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    state_next = state;
    set_short  = 1'b0;
    set_long   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_next = s.s_last ? COMMIT : FILL;
          set_short  = s.s_last;
        end
      end
      FILL: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            state_next = s.s_last ? COMMIT : DRAIN;
            set_long   = ~s.s_last;
          end else if (s.s_last) begin
            state_next = COMMIT;
            set_short  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (xfer && s.s_last) state_next = COMMIT;
      end
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the wide assembly register is reset too, since data is an output with a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      data  <= '0;
      load  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      load  <= (state_next == COMMIT);
      busy  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (xfer) begin
            data <= {{(CA_W - WORD_W){1'b0}}, s.s_data};
            idx  <= IDX_W'(1);
          end
        end
        FILL: begin
          if (xfer) begin
            data[idx*WORD_W +: WORD_W] <= s.s_data;
            // Saturate on the last slot; DRAIN keeps it parked there.
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        COMMIT:  idx <= '0;
        default: ;
      endcase
    end
  end

  // A clear wins over a set landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else if (err_clr) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      if (set_short) err_short <= 1'b1;
      if (set_long)  err_long  <= 1'b1;
    end
  end

`ifdef RULE90_SEED_LOADER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
    end else if (state_next == COMMIT) begin
      load_cnt <= load_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rule90_seed_loader.sv
// Self-checking bench for rule90_seed_loader: frame-level model plus directed literal checks.
module tb_rule90_seed_loader;
  import rule90_pkg::*;

  localparam int CA_W   = RULE90_CA_W;
  localparam int WORD_W = RULE90_WORD_W;
  localparam int WORDS  = CA_W / WORD_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              err_clr = 1'b0;
  logic              load;
  logic [CA_W-1:0]   data;
  logic              busy;
  logic              err_short;
  logic              err_long;
`ifdef RULE90_SEED_LOADER_CNT_EN
  logic [15:0]       load_cnt;
`endif

  rule90_seed_loader_if #(.WORD_W(WORD_W)) sif ();

  rule90_seed_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (sif),
    .load      (load),
    .data      (data),
    .busy      (busy),
    .err_short (err_short),
    .err_long  (err_long),
    .err_clr   (err_clr)
`ifdef RULE90_SEED_LOADER_CNT_EN
    ,
    .load_cnt  (load_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [CA_W-1:0] act, input logic [CA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: collect the words of a frame, build the seed when it ends.
  logic [WORD_W-1:0] m_words[$];
  bit                m_load = 1'b0;
  bit                m_busy = 1'b0;
  bit                m_es   = 1'b0;
  bit                m_el   = 1'b0;
  logic [CA_W-1:0]   m_data = '0;
  logic [15:0]       m_cnt  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_words.delete();
      m_load = 1'b0;
      m_busy = 1'b0;
      m_es   = 1'b0;
      m_el   = 1'b0;
      m_data = '0;
      m_cnt  = '0;
    end else begin
      bit take, new_load, set_s, set_l;
      int n;
      take     = sif.s_valid && !m_load;
      new_load = 1'b0;
      set_s    = 1'b0;
      set_l    = 1'b0;
      if (take) begin
        m_words.push_back(sif.s_data);
        n = m_words.size();
        if (n == WORDS && !sif.s_last) set_l = 1'b1;
        if (sif.s_last) begin
          new_load = 1'b1;
          set_s    = (n < WORDS);
          m_data   = '0;
          for (int i = 0; i < n && i < WORDS; i++) m_data[i*WORD_W +: WORD_W] = m_words[i];
          m_words.delete();
        end
      end
      if (err_clr) begin
        m_es = 1'b0;
        m_el = 1'b0;
      end else begin
        m_es = m_es | set_s;
        m_el = m_el | set_l;
      end
      if (new_load) m_cnt = m_cnt + 16'd1;
      m_load = new_load;
      m_busy = (m_words.size() != 0) || new_load;
    end
  end

  int              cyc = 0;
  int              load_cycles[$];
  int              ready_low = 0;
  logic [CA_W-1:0] cap = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    check("load", load, m_load);
    check("busy", busy, m_busy);
    check("err_short", err_short, m_es);
    check("err_long", err_long, m_el);
    if (rst_n) check("s_ready", sif.s_ready, !m_load);
    if (m_load || !m_busy) check("data", data, m_data);
`ifdef RULE90_SEED_LOADER_CNT_EN
    check("load_cnt", load_cnt, m_cnt);
`endif
    if (load) begin
      cap = data;
      load_cycles.push_back(cyc);
    end
    if (!sif.s_ready) ready_low++;
  end

  // Present a word and return just after the edge on which it transferred.
  task automatic send(input logic [WORD_W-1:0] w, input bit last, input bit clr = 1'b0);
    int n = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = w;
    sif.s_last  = last;
    err_clr     = clr;
    while (!sif.s_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!sif.s_ready) check("ready_timeout", sif.s_ready, 1);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n, input logic [WORD_W-1:0] base);
    for (int i = 0; i < n; i++) send(base + WORD_W'(i), i == n - 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_load", load, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    check("rst_err_short", err_short, 0);
    check("rst_err_long", err_long, 0);
    rst_n = 1'b1;
    #1;
    check("rst_s_ready", sif.s_ready, 1);
    idle(2);

    // Full frame 1..16
    load_cycles.delete();
    frame(16, 32'h1);
    idle(3);
    check("full_loads", load_cycles.size(), 1);
    check("full_word0", cap[31:0], 32'h1);
    check("full_word15", cap[511:480], 32'h10);
    check("full_err_short", err_short, 0);
    check("full_err_long", err_long, 0);

    // Short frame of three all-ones words
    load_cycles.delete();
    for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, i == 2);
    idle(3);
    check("short_loads", load_cycles.size(), 1);
    check("short_low", cap[95:0], {96{1'b1}});
    check("short_high", cap[511:96], 0);
    check("short_err_short", err_short, 1);

    // Overlong frame of 18 words
    load_cycles.delete();
    frame(18, 32'h100);
    idle(3);
    check("long_loads", load_cycles.size(), 1);
    check("long_err_long", err_long, 1);
    check("long_word0", cap[31:0], 32'h100);
    check("long_word15", cap[511:480], 32'h10F);

    // Clear on the same cycle as a short-frame end: the set is lost
    send(32'hA, 1'b0);
    send(32'hB, 1'b1, 1'b1);
    idle(3);
    check("clr_err_short", err_short, 0);
    check("clr_err_long", err_long, 0);

    // Reset after word 7, then a fresh full frame
    load_cycles.delete();
    for (int i = 0; i < 7; i++) send(32'h200 + 32'(i), 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("abort_loads", load_cycles.size(), 0);
    frame(16, 32'h300);
    idle(3);
    check("abort_new_loads", load_cycles.size(), 1);
    check("abort_word0", cap[31:0], 32'h300);
    check("abort_word7", cap[255:224], 32'h307);
    check("abort_word15", cap[511:480], 32'h30F);

    // Back-to-back frames with valid held high
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    load_cycles.delete();
    ready_low = 0;
    frame(16, 32'h400);
    frame(16, 32'h500);
    check("b2b_ready_low", ready_low, 1);
    idle(3);
    check("b2b_loads", load_cycles.size(), 2);
    if (load_cycles.size() == 2) check("b2b_spacing", load_cycles[1] - load_cycles[0], 17);
    check("b2b_word0", cap[31:0], 32'h500);
`ifdef RULE90_SEED_LOADER_CNT_EN
    check("b2b_load_cnt", load_cnt, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
